// File: rtl/bus8088_pkg.sv
// Shared types for the 8088-style minimum-mode bus.
// Bus state encoding, widths and the latched request bundle.
package bus8088_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    TI,
    T1,
    T2,
    T3,
    TW,
    T4
  } bus_state_t;

  typedef struct packed {
    logic              write;
    logic              io;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_master_8088.sv
// 8088 minimum-mode bus initiator: one byte per T1-T2-T3-(Tw)*-T4 cycle.
// Ports: CLK/RESET; req_* valid/ready request in; rsp_* one-cycle
// response out; ALE/RD/WR/IOM/Address/Data/READY to the bus.
module bus_master_8088
  import bus8088_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic              IOM,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data,
  input  logic              READY
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  bus_state_t        r_state;
  bus_state_t        w_next;
  bus_req_t          r_req;
  logic [CW-1:0]     r_wcnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic w_accept;
  logic w_strobe;
  logic w_timeout;
  logic w_done;
  logic w_drive;

  assign req_ready = ((r_state == TI) || (r_state == T4)) && !RESET;
  assign w_accept  = req_valid && req_ready;
  assign w_strobe  = (r_state == T2) || (r_state == T3) ||
                     (r_state == TW);

  // The wait count reflects completed TW cycles; the last allowed
  // TW is the one where the incremented count would hit MAX_WAIT.
  assign w_timeout = (r_state == TW) && !READY &&
                     (r_wcnt == CW'(MAX_WAIT - 1));
  assign w_done    = ((r_state == T3) || (r_state == TW)) && READY;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= TI;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      TI:      w_next = w_accept ? T1 : TI;
      T1:      w_next = T2;
      T2:      w_next = T3;
      T3:      w_next = READY ? T4 : TW;
      TW:      w_next = (READY || w_timeout) ? T4 : TW;
      T4:      w_next = w_accept ? T1 : TI;
      default: w_next = TI;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_req   <= '0;
      r_wcnt  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req <= '{write: req_write, io: req_io,
                   addr: req_addr, wdata: req_wdata};
      end
      if (r_state == T2)      r_wcnt <= '0;
      else if (r_state == TW) r_wcnt <= r_wcnt + 1'b1;
      if (w_done && !r_req.write) r_rdata <= Data;
      if (w_next == T4) r_err <= w_timeout;
    end
  end

  assign ALE       = (r_state == T1);
  assign RD        = !(w_strobe && !r_req.write);
  assign WR        = !(w_strobe && r_req.write);
  assign IOM       = r_req.io;
  assign Address   = r_req.addr;

  // Never driven in T1, so a read's responder always gets a turnaround.
  assign w_drive   = r_req.write && (w_strobe || (r_state == T4));
  assign Data      = w_drive ? r_req.wdata : {DATA_W{1'bz}};

  assign rsp_valid = (r_state == T4);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err && rsp_valid;

endmodule

// File: tb/tb_bus_master_8088.sv
// Self-checking bench for bus_master_8088 with a memory responder.
// Random and directed transactions checked against a byte-level model.
module tb_bus_master_8088;

  localparam int MAXW = 15;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_io = 1'b0;
  logic [19:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        ALE;
  logic        RD;
  logic        WR;
  logic        IOM;
  logic [19:0] Address;
  tri   [7:0]  Data;
  logic        READY = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:(1<<20)-1];
  logic [7:0] ref_mem [int];
  logic [7:0] exp_rdata = '0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup pu (Data[g]);
  end

  assign Data = (!RD) ? mem[Address] : 8'bz;

  always @(posedge CLK) begin
    if (!WR) mem[Address] <= Data;
  end

  bus_master_8088 #(.MAX_WAIT(MAXW)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_io   (req_io),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .ALE      (ALE),
    .RD       (RD),
    .WR       (WR),
    .IOM      (IOM),
    .Address  (Address),
    .Data     (Data),
    .READY    (READY)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [19:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return a[7:0];
  endfunction

  // One transaction; READY held low for nw clocks starting at T3.
  task automatic run_txn(input logic w, input logic io,
                         input logic [19:0] a, input logic [7:0] d,
                         input int nw);
    int  waits, exp_len, cyc, ale_n, rd_n, wr_n, bad;
    bit  done;
    logic err_exp;
    waits   = (nw > MAXW) ? MAXW : nw;
    exp_len = 4 + waits;
    err_exp = (nw > MAXW);
    if (w) ref_mem[int'(a)] = d;
    else if (!err_exp) exp_rdata = model_rd(a);
    @(negedge CLK);
    req_valid = 1'b1; req_write = w; req_io = io;
    req_addr = a; req_wdata = d;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    check("accept_ready", req_ready, 1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0; req_write = ~w;
    req_addr = 20'($urandom); req_wdata = 8'($urandom);
    ale_n = 0; rd_n = 0; wr_n = 0; bad = 0; done = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge CLK);
      if (ALE) ale_n++;
      if (!RD) rd_n++;
      if (!WR) wr_n++;
      if (k == 1) begin
        check("t1_ale", ALE, 1);
        check("t1_addr", Address, a);
        check("t1_iom", IOM, io);
        check("t1_data_z", Data, 8'hFF);
      end
      if (w && k >= 2 && Data !== d) bad++;
      if (rsp_valid) begin
        done = 1;
        check("cycle_len", k, exp_len);
        check("rsp_err", rsp_err, err_exp);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("t4_strobes", {RD, WR}, 2'b11);
        if (!w) check("t4_data_z", Data, 8'hFF);
      end
      READY = !(k >= 3 && k < 3 + nw);
    end
    READY = 1'b1;
    check("rsp_seen", done, 1);
    check("ale_count", ale_n, 1);
    check("rd_count", rd_n, w ? 0 : exp_len - 2);
    check("wr_count", wr_n, w ? exp_len - 2 : 0);
    if (w) check("wdata_bus", bad, 0);
  endtask

  // n reads with req_valid held; expects T4 -> T1 with no idle gap.
  task automatic run_b2b(input int n);
    logic [19:0] addrs [$];
    int idx, k, pulses, ale_n, bad_z;
    bit acc;
    for (int i = 0; i < n; i++) addrs.push_back(20'($urandom));
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0;
    req_addr = addrs[0];
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check("b2b_ready", req_ready, 1);
    idx = 0; k = 0; pulses = 0; ale_n = 0; bad_z = 0;
    while (pulses < n && k < 100) begin
      acc = req_valid && req_ready;
      @(negedge CLK);
      k++;
      if (acc) begin
        idx++;
        if (idx < n) req_addr = addrs[idx];
        else req_valid = 1'b0;
      end
      if (ALE) begin
        ale_n++;
        if (Data !== 8'hFF) bad_z++;
      end
      if (rsp_valid) begin
        exp_rdata = model_rd(addrs[pulses]);
        check("b2b_rdata", rsp_rdata, exp_rdata);
        pulses++;
      end
    end
    req_valid = 1'b0;
    check("b2b_pulses", pulses, n);
    check("b2b_len", k, 4 * n);
    check("b2b_ale", ale_n, n);
    check("b2b_t1_z", bad_z, 0);
  endtask

  initial begin
    logic [19:0] ra;
    logic [7:0]  rd;
    for (int i = 0; i < (1 << 20); i++) mem[i] = 8'(i);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", req_ready, 0);
    check("rst_ale", ALE, 0);
    check("rst_strobes", {RD, WR}, 2'b11);
    check("rst_iom", IOM, 0);
    check("rst_addr", Address, 0);
    check("rst_data_z", Data, 8'hFF);
    check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    check("rst_rdata", rsp_rdata, 0);
    RESET = 1'b0;
    @(negedge CLK);
    check("idle_ready", req_ready, 1);

    run_txn(1'b0, 1'b0, 20'h01234, 8'h00, 0);
    run_txn(1'b1, 1'b0, 20'h00010, 8'hA5, 0);
    run_txn(1'b0, 1'b0, 20'h00010, 8'h00, 0);

    for (int i = 0; i < 8; i++) begin
      run_txn(1'($urandom), 1'($urandom),
              20'($urandom_range(0, 63)),
              8'($urandom_range(0, 254)),
              int'($urandom_range(0, 3)));
    end

    run_txn(1'b0, 1'b1, 20'h0ABCD, 8'h00, 2);
    run_txn(1'b0, 1'b0, 20'h00020, 8'h00, MAXW);
    run_txn(1'b0, 1'b0, 20'h00033, 8'h00, 100);
    run_txn(1'b1, 1'b1, 20'h00040, 8'h5C, 100);
    run_txn(1'b0, 1'b1, 20'h00040, 8'h00, 0);

    run_b2b(3);

    ra = 20'($urandom_range(100, 200));
    rd = 8'($urandom_range(0, 254));
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_io = 1'b0;
    req_addr = ra; req_wdata = rd;
    while (!req_ready) @(negedge CLK);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("mid_wr_low", WR, 0);
    RESET = 1'b1;
    ref_mem[int'(ra)] = rd;
    exp_rdata = '0;
    @(negedge CLK);
    check("mid_strobes", {RD, WR}, 2'b11);
    check("mid_ale", ALE, 0);
    check("mid_data_z", Data, 8'hFF);
    check("mid_rsp", rsp_valid, 0);
    check("mid_ready", req_ready, 0);
    check("mid_rdata", rsp_rdata, 0);
    RESET = 1'b0;
    @(negedge CLK);
    check("post_rsp", rsp_valid, 0);
    check("post_ready", req_ready, 1);
    run_txn(1'b0, 1'b0, ra, 8'h00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
